mem_io_responder: RTL

Bus responder at the far end of the CPU memory port. Services the CPU's byte-wide read/write requests. Backs 0x00000–0x1FFFF with a synchronous RAM and maps I/O at mem_a[17:16]==2'b11: UART-style rx/tx byte streams, a free-running cycle counter and a program-stop flag. Used in simulation and FPGA top level in place of the board memory/HCI, and drives the CPU's rdy_in for tx backpressure.

---
 rtl/mem_io_pkg.sv | 8 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/mem_io_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared decode constants for the memory/I-O responder
package mem_io_pkg;
   localparam logic [1:0]  IO_SEL           = 2'b11;
   localparam logic [1:0]  HOLE_SEL         = 2'b10;
   localparam logic [17:0] ADDR_IO_DATA     = 18'h30000;
   localparam logic [17:0] ADDR_IO_CLK      = 18'h30004;
   localparam logic [17:0] ADDR_IO_CLK_LAST = 18'h30007;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_do_push, w_do_pop;
   assign o_empty   = r_cnt == '0;
   assign o_full    = r_cnt[AW];
   assign o_count   = r_cnt;
   assign o_dout    = r_mem[r_rp];
   assign w_do_pop  = i_pop && !o_empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_do_push = i_push && (!o_full || w_do_pop);
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wp] <= i_din;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + 1'b1;
         if (w_do_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
      end
   end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus rx/tx streams, cycle counter and stop flag on the CPU memory port
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   output logic        rdy_out,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        program_stop,
   output logic        tx_overflow
);
   localparam logic [FIFO_AW:0] TX_HI = (FIFO_AW+1)'((1 << FIFO_AW) - 2);
   logic [7:0]       r_ram [0:(1<<RAM_AW)-1];
   logic [17:0]      w_a, r_last_a;
   logic [1:0]       w_sel;
   logic             w_is_ram, w_rx_rd, w_rx_pop, w_rx_push, w_tx_push, w_tx_pop;
   logic             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, w_unused;
   logic [7:0]       w_rx_dout, w_tx_dout, w_io_byte;
   logic [FIFO_AW:0] w_rx_count, w_tx_count;
   logic [31:0]      r_cnt, r_snap;
   logic [7:0]       r_ram_q, r_io_q, r_rdata;
   logic             r_last_wr, r_rd_v, r_rd_ram, r_rdy, r_stop, r_ovf;
   assign w_a       = mem_a[17:0];
   assign w_sel     = mem_a[17:16];
   assign w_is_ram  = w_sel != IO_SEL && w_sel != HOLE_SEL;
   assign w_rx_rd   = !mem_wr && w_a == ADDR_IO_DATA;
   // a bus held on the same read (CPU stalled) must not drain the rx stream again
   assign w_rx_pop  = w_rx_rd && !(!r_last_wr && r_last_a == ADDR_IO_DATA);
   assign w_rx_push = rx_valid && !w_rx_full;
   assign w_tx_push = mem_wr && w_a == ADDR_IO_DATA && mem_wdata != 8'h00;
   assign w_tx_pop  = !w_tx_empty && tx_ready;
   assign w_io_byte = (w_a == ADDR_IO_DATA) ? (w_rx_empty ? 8'h00 : w_rx_dout)
                    : (w_a == ADDR_IO_CLK) ? r_cnt[7:0]
                    : (w_a > ADDR_IO_CLK && w_a <= ADDR_IO_CLK_LAST) ? r_snap[{w_a[1:0], 3'b000} +: 8]
                    : 8'h00;
   assign w_unused  = ^{mem_a[31:18], w_rx_count};
   assign mem_rdata    = r_rdata;
   assign rdy_out      = r_rdy;
   assign rx_ready     = !w_rx_full;
   assign tx_valid     = !w_tx_empty;
   assign tx_data      = w_tx_dout;
   assign program_stop = r_stop;
   assign tx_overflow  = r_ovf;
   sync_fifo #(.DW(8), .AW(FIFO_AW)) u_rx (
      .i_clk(clk_in), .i_rst_n(rst_in), .i_push(w_rx_push), .i_pop(w_rx_pop), .i_din(rx_data),
      .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
   );
   sync_fifo #(.DW(8), .AW(FIFO_AW)) u_tx (
      .i_clk(clk_in), .i_rst_n(rst_in), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_din(mem_wdata),
      .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
   );
   always_ff @(posedge clk_in) begin
      if (mem_wr && w_is_ram) r_ram[mem_a[RAM_AW-1:0]] <= mem_wdata;
      r_ram_q <= r_ram[mem_a[RAM_AW-1:0]];
   end
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_last_a  <= '0;
         r_last_wr <= 1'b0;
         r_cnt     <= '0;
         r_snap    <= '0;
         r_io_q    <= '0;
         r_rdata   <= '0;
         r_rd_v    <= 1'b0;
         r_rd_ram  <= 1'b0;
         r_rdy     <= 1'b1;
         r_stop    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_last_a  <= w_a;
         r_last_wr <= mem_wr;
         if (!r_stop) r_cnt <= r_cnt + 32'd1;
         if (!mem_wr && w_a == ADDR_IO_CLK) r_snap <= r_cnt;
         if (mem_wr && w_a == ADDR_IO_CLK) r_stop <= 1'b1;
         if (w_tx_push && w_tx_full && !w_tx_pop) r_ovf <= 1'b1;
         r_io_q    <= w_io_byte;
         r_rd_ram  <= w_is_ram;
         r_rd_v    <= !mem_wr && !(w_rx_rd && !w_rx_pop);
         if (r_rd_v) r_rdata <= r_rd_ram ? r_ram_q : r_io_q;
         r_rdy     <= w_tx_count < TX_HI;
      end
   end
endmodule
